// File: rtl/mcu_port_arbiter.sv
// Two-port arbiter in front of the DDR controller user port: CPU refill path on
// port 0, DMA on port 1. One transaction in flight, with a watchdog on mem_ack.
//
// state   | meaning
// IDLE    | no transaction; pick a winner when req0/req1 is high
// ISSUE   | mem_do_act held, waiting for mem_ack or watchdog expiry
// RELEASE | one quiet cycle so the served requester can drop req
module mcu_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int FIXED_PRIO = 0,
   parameter int TIMEOUT    = 1024,
   parameter int TW         = 11
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic          we0,
   input  logic          we1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          err0,
   output logic          err1,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic          mem_do_act,
   output logic [DW-1:0] mem_dataintomem,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_datafrommem,
   output logic          busy,
   output logic          grant
);

   typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

   localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          grant_q, grant_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          mem_we_q, mem_we_d;
   logic          mem_do_act_q, mem_do_act_d;
   logic [DW-1:0] mem_din_q, mem_din_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d;
   logic          err0_q, err0_d, err1_q, err1_d;
   logic          busy_q, busy_d;
   logic          win;

   // Port 1 wins when alone, or on a round-robin tie after port 0 was last served.
   assign win = req1 && (!req0 || (FIXED_PRIO == 0 && !last_grant_q));

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      cnt_d        = cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = mem_we_q;
      mem_do_act_d = mem_do_act_q;
      mem_din_d    = mem_din_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               mem_addr_d   = win ? addr1 : addr0;
               mem_we_d     = win ? we1 : we0;
               mem_din_d    = win ? wdata1 : wdata0;
               mem_do_act_d = 1'b1;
               grant_d      = win;
               last_grant_d = win;
               cnt_d        = '0;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               if (!mem_we_q) begin
                  if (grant_q) rdata1_d = mem_datafrommem;
                  else         rdata0_d = mem_datafrommem;
               end
               ack0_d       = !grant_q;
               ack1_d       = grant_q;
               mem_do_act_d = 1'b0;
               state_d      = RELEASE;
            end else if (TIMEOUT != 0) begin
               if (cnt_q == CNT_LAST) begin
                  err0_d       = !grant_q;
                  err1_d       = grant_q;
                  mem_do_act_d = 1'b0;
                  state_d      = RELEASE;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         cnt_q        <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_do_act_q <= 1'b0;
         mem_din_q    <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_do_act_q <= mem_do_act_d;
         mem_din_q    <= mem_din_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
         busy_q       <= busy_d;
      end
   end

   assign ack0            = ack0_q;
   assign ack1            = ack1_q;
   assign err0            = err0_q;
   assign err1            = err1_q;
   assign rdata0          = rdata0_q;
   assign rdata1          = rdata1_q;
   assign mem_addr        = mem_addr_q;
   assign mem_we          = mem_we_q;
   assign mem_do_act      = mem_do_act_q;
   assign mem_dataintomem = mem_din_q;
   assign busy            = busy_q;
   assign grant           = grant_q;

endmodule

// File: tb/tb_mcu_port_arbiter.sv
// Bench for mcu_port_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of arbitration, ack/timeout and read data.
module tb_mcu_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0, mem_ack = 0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0, mem_dfm = '0;

   logic          ack0, ack1, err0, err1, mem_we, mem_do_act, busy, grant;
   logic [DW-1:0] rdata0, rdata1, mem_din;
   logic [AW-1:0] mem_addr;
   logic          b_ack0, b_ack1, b_err0, b_err1, b_mem_we, b_mem_do_act, b_busy, b_grant;
   logic [DW-1:0] b_rdata0, b_rdata1, b_mem_din;
   logic [AW-1:0] b_mem_addr;

   always #5 clk = ~clk;

   mcu_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .TIMEOUT(TO), .TW(11)) dut (
      .CLK(clk), .RST(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_do_act(mem_do_act), .mem_dataintomem(mem_din),
      .mem_ack(mem_ack), .mem_datafrommem(mem_dfm), .busy(busy), .grant(grant));

   mcu_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .TIMEOUT(TO), .TW(11)) dut_fp (
      .CLK(clk), .RST(rst), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1), .err0(b_err0), .err1(b_err1),
      .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_do_act(b_mem_do_act), .mem_dataintomem(b_mem_din),
      .mem_ack(mem_ack), .mem_datafrommem(mem_dfm), .busy(b_busy), .grant(b_grant));

   int n_pass = 0, n_total = 0;

   // Reference model state: who was served last and what each port last read.
   logic          m_last;
   logic [DW-1:0] m_rdata [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0 = 0; req1 = 0; mem_ack = 0;
      #1;
      chk("rst_acks_errs", {ack0, ack1, err0, err1}, 0);
      chk("rst_busy_grant", {busy, grant}, 0);
      chk("rst_mem_ctl", {mem_do_act, mem_we}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_rdata", {rdata0, rdata1}, 0);
      chk("rst_fp_do_act", b_mem_do_act, 0);
      @(negedge clk);
      rst = 1'b0;
      m_last = 1'b1;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
      @(negedge clk);
   endtask

   // Runs one transaction from an IDLE negedge with req levels already set.
   // lat = ISSUE cycle in which the controller acks; lat >= TO means never.
   task automatic serve(input int lat, input bit drop_winner, input logic [DW-1:0] rd);
      int            w;
      logic [AW-1:0] ea;
      logic          ewe;
      logic [DW-1:0] ed;
      bit            done;
      w   = (req0 && req1) ? (m_last ? 0 : 1) : (req0 ? 0 : 1);
      ea  = (w == 1) ? addr1 : addr0;
      ewe = (w == 1) ? we1 : we0;
      ed  = (w == 1) ? wdata1 : wdata0;
      m_last = (w == 1);
      @(posedge clk);
      @(negedge clk);
      chk("issue_do_act", mem_do_act, 1);
      chk("issue_grant", grant, w);
      chk("issue_addr", mem_addr, ea);
      chk("issue_we", mem_we, ewe);
      if (ewe) chk("issue_wdata", mem_din, ed);
      done = 0;
      for (int k = 0; k < TO && !done; k++) begin
         mem_ack = (k == lat);
         mem_dfm = rd;
         @(negedge clk);
         mem_ack = 0;
         mem_dfm = $urandom;
         if (k == lat) begin
            if (!ewe) m_rdata[w] = rd;
            chk("ack_ports", {ack0, ack1, err0, err1}, (w == 0) ? 4'b1000 : 4'b0100);
            chk("ack_do_act_drop", mem_do_act, 0);
            done = 1;
         end else if (k == TO - 1) begin
            chk("err_ports", {ack0, ack1, err0, err1}, (w == 0) ? 4'b0010 : 4'b0001);
            chk("err_do_act_drop", mem_do_act, 0);
            done = 1;
         end else begin
            chk("wait_quiet", {ack0, ack1, err0, err1, mem_do_act}, 5'b00001);
         end
      end
      chk("rdata0", rdata0, m_rdata[0]);
      chk("rdata1", rdata1, m_rdata[1]);
      chk("release_busy", busy, 1);
      if (drop_winner) begin
         if (w == 0) req0 = 0;
         else        req1 = 0;
      end
      @(negedge clk);
      chk("idle_quiet", {busy, mem_do_act, ack0, ack1, err0, err1}, 0);
      chk("idle_hold", {grant, mem_addr}, {w[0], ea});
   endtask

   initial begin
      #2;
      do_reset();

      // single read on port 0
      addr0 = 32'h0000_0010; we0 = 0; req0 = 1;
      serve(3, 1, 32'h5a5a_dadd);
      chk("read_rdata0", rdata0, 32'h5a5a_dadd);

      // single write on port 1
      addr1 = 32'h0010_0080; wdata1 = 32'h1234_5678; we1 = 1; req1 = 1;
      serve(2, 1, 32'hdead_beef);
      chk("write_rdata1_unchanged", rdata1, 0);

      // simultaneous held requests: RR 0,1,0,1; fixed priority 0,0,0,0
      do_reset();
      addr0 = 32'h100; we0 = 0; addr1 = 32'h200; we1 = 0; req0 = 1; req1 = 1;
      for (int i = 0; i < 4; i++) begin
         serve(1, 0, $urandom);
         chk("rr_order", grant, i % 2);
         chk("fp_order", b_grant, 0);
      end
      req0 = 0; req1 = 0;
      @(negedge clk);

      // watchdog expiry, then ack landing exactly in the expiry cycle
      addr0 = 32'h40; we0 = 0; req0 = 1;
      serve(99, 1, 32'h1111_2222);
      @(negedge clk);
      chk("wd_idle_after", {busy, ack0, ack1, err0, err1}, 0);
      req0 = 1;
      serve(TO - 1, 1, 32'h3333_4444);

      // reset mid-ISSUE, stray ack, then a normal request on port 1
      addr0 = 32'h80; we0 = 0; req0 = 1;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_do_act", mem_do_act, 1);
      do_reset();
      mem_ack = 1;
      @(negedge clk);
      mem_ack = 0;
      chk("stray_ack_ignored", {ack0, ack1, err0, err1, busy}, 0);
      addr1 = 32'h0000_0c00; we1 = 0; req1 = 1;
      serve(4, 1, 32'h7777_8888);

      // random traffic
      for (int i = 0; i < 40; i++) begin
         if (!req0 && $urandom_range(0, 1) == 1) begin
            req0 = 1; addr0 = $urandom; we0 = $urandom_range(0, 1); wdata0 = $urandom;
         end
         if (!req1 && $urandom_range(0, 1) == 1) begin
            req1 = 1; addr1 = $urandom; we1 = $urandom_range(0, 1); wdata1 = $urandom;
         end
         if (!req0 && !req1) begin
            req1 = 1; addr1 = $urandom; we1 = $urandom_range(0, 1); wdata1 = $urandom;
         end
         serve($urandom_range(0, 20), 1, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
